// File: rtl/uart_cmd_rx_if.sv
// Command handshake between the UART command receiver (master) and its consumer (slave).
interface uart_cmd_rx_if;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        frm_err;
    logic        clr_cmd_rdy;

    modport master (output cmd, output cmd_rdy, output frm_err, input clr_cmd_rdy);
    modport slave  (input cmd, input cmd_rdy, input frm_err, output clr_cmd_rdy);
endinterface

// File: rtl/uart_cmd_rx.sv
// 8N1 UART receiver packing byte pairs (high byte first) into 16-bit commands.
// Optional inter-byte timeout enabled by defining CMD_BYTE_TIMEOUT_EN.
module uart_cmd_rx #(
    parameter int BAUD_DIV     = 2604,
    parameter int TIMEOUT_CLKS = 1_000_000
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          RX,
    uart_cmd_rx_if.master bus
);

    localparam int CNT_W = $clog2(BAUD_DIV);

    typedef enum logic [2:0] {B_IDLE, B_START, B_DATA, B_STOP, B_BREAK} bit_state_t;
    typedef enum logic       {P_HI, P_LO} pair_state_t;

    generate
        if (BAUD_DIV < 8 || TIMEOUT_CLKS < 2) begin : g_param_check
            $error("uart_cmd_rx: BAUD_DIV must be >= 8 and TIMEOUT_CLKS >= 2");
        end
    endgenerate

    logic              r_rx_meta, r_rx_sync, r_rx_prev;
    logic              w_start_det;
    bit_state_t        r_bit_state, w_bit_nxt;
    logic [CNT_W-1:0]  r_baud_cnt, w_baud_nxt;
    logic [2:0]        r_bit_idx, w_idx_nxt;
    logic [7:0]        r_shift, w_shift_nxt;
    logic              w_baud_zero, w_byte_done, w_frm_err;
    pair_state_t       r_pair, w_pair_nxt;
    logic              w_hi_load, w_cmd_load, w_timeout;
    logic [7:0]        r_hi_byte;
    logic [15:0]       r_cmd;
    logic              r_cmd_rdy, r_frm_err;

    // Two-flop synchroniser plus one more stage for falling-edge detection; idle level is 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_meta <= RX;
            r_rx_sync <= r_rx_meta;
            r_rx_prev <= r_rx_sync;
        end
    end

    assign w_start_det = r_rx_prev & ~r_rx_sync;
    assign w_baud_zero = (r_baud_cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_bit_state <= B_IDLE;
        else        r_bit_state <= w_bit_nxt;
    end

    always_comb begin
        w_bit_nxt   = r_bit_state;
        w_baud_nxt  = w_baud_zero ? r_baud_cnt : r_baud_cnt - 1'b1;
        w_idx_nxt   = r_bit_idx;
        w_shift_nxt = r_shift;
        w_byte_done = 1'b0;
        w_frm_err   = 1'b0;
        case (r_bit_state)
            B_IDLE: begin
                if (w_start_det) begin
                    w_baud_nxt = CNT_W'(BAUD_DIV / 2);
                    w_bit_nxt  = B_START;
                end
            end
            B_START: begin
                if (w_baud_zero) begin
                    if (r_rx_sync) begin
                        w_bit_nxt = B_IDLE;
                    end else begin
                        w_baud_nxt = CNT_W'(BAUD_DIV - 1);
                        w_idx_nxt  = 3'd0;
                        w_bit_nxt  = B_DATA;
                    end
                end
            end
            B_DATA: begin
                if (w_baud_zero) begin
                    w_shift_nxt = {r_rx_sync, r_shift[7:1]};
                    w_baud_nxt  = CNT_W'(BAUD_DIV - 1);
                    if (r_bit_idx == 3'd7) w_bit_nxt = B_STOP;
                    else                   w_idx_nxt = r_bit_idx + 3'd1;
                end
            end
            B_STOP: begin
                if (w_baud_zero) begin
                    if (r_rx_sync) begin
                        w_byte_done = 1'b1;
                        w_bit_nxt   = B_IDLE;
                    end else begin
                        w_frm_err = 1'b1;
                        w_bit_nxt = B_BREAK;
                    end
                end
            end
            B_BREAK: begin
                // Line held low after a bad stop bit: re-arm only once it returns high.
                if (r_rx_sync) w_bit_nxt = B_IDLE;
            end
            default: w_bit_nxt = B_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_baud_cnt <= '0;
            r_bit_idx  <= 3'd0;
            r_shift    <= 8'h00;
        end else begin
            r_baud_cnt <= w_baud_nxt;
            r_bit_idx  <= w_idx_nxt;
            r_shift    <= w_shift_nxt;
        end
    end

`ifdef CMD_BYTE_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CLKS);
    logic [TO_W-1:0] r_to_cnt;
    logic            r_to_run;

    assign w_timeout = r_to_run && (r_to_cnt == TO_W'(TIMEOUT_CLKS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_to_run <= 1'b0;
            r_to_cnt <= '0;
        end else if (w_hi_load) begin
            r_to_run <= 1'b1;
            r_to_cnt <= '0;
        end else if (w_start_det || r_pair != P_LO || w_timeout) begin
            r_to_run <= 1'b0;
        end else if (r_to_run) begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_pair <= P_HI;
        else        r_pair <= w_pair_nxt;
    end

    always_comb begin
        w_pair_nxt = r_pair;
        w_hi_load  = 1'b0;
        w_cmd_load = 1'b0;
        if (w_frm_err) begin
            w_pair_nxt = P_HI;
        end else if (w_byte_done) begin
            if (r_pair == P_HI) begin
                w_hi_load  = 1'b1;
                w_pair_nxt = P_LO;
            end else begin
                w_cmd_load = 1'b1;
                w_pair_nxt = P_HI;
            end
        end else if (w_timeout) begin
            w_pair_nxt = P_HI;
        end
    end

    // A new command always lands, even over an unconsumed one; set beats clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hi_byte <= 8'h00;
            r_cmd     <= 16'h0000;
            r_cmd_rdy <= 1'b0;
            r_frm_err <= 1'b0;
        end else begin
            r_frm_err <= w_frm_err;
            if (w_hi_load)  r_hi_byte <= r_shift;
            if (w_cmd_load) r_cmd     <= {r_hi_byte, r_shift};
            if (w_cmd_load)            r_cmd_rdy <= 1'b1;
            else if (bus.clr_cmd_rdy)  r_cmd_rdy <= 1'b0;
        end
    end

    assign bus.cmd     = r_cmd;
    assign bus.cmd_rdy = r_cmd_rdy;
    assign bus.frm_err = r_frm_err;

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Directed bench for uart_cmd_rx at BAUD_DIV=16, TIMEOUT_CLKS=2000.
module tb_uart_cmd_rx;

    localparam int BAUD = 16;

    logic clk = 1'b0;
    logic rst_n;
    logic rx;
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    int   frm_cnt = 0;
    int   rise_cyc = 0;
    int   t_start = 0;
    logic rdy_q = 1'b0;

    uart_cmd_rx_if u_if ();

    uart_cmd_rx #(.BAUD_DIV(BAUD), .TIMEOUT_CLKS(2000)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .RX    (rx),
        .bus   (u_if)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (u_if.frm_err === 1'b1) frm_cnt++;
        if (u_if.cmd_rdy === 1'b1 && !rdy_q) rise_cyc = cyc;
        rdy_q = (u_if.cmd_rdy === 1'b1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        @(negedge clk);
        rx = 1'b0;
        t_start = cyc;
        repeat (BAUD) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (BAUD) @(negedge clk);
        end
        rx = stop_bit;
        repeat (BAUD) @(negedge clk);
        rx = 1'b1;
        repeat (BAUD) @(negedge clk);
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        u_if.clr_cmd_rdy = 1'b1;
        @(negedge clk);
        u_if.clr_cmd_rdy = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat;
        int frm_base;
        rst_n = 1'b0;
        rx = 1'b1;
        u_if.clr_cmd_rdy = 1'b0;
        repeat (4) @(negedge clk);
        check("rst_cmd", 32'(u_if.cmd), 32'h0000);
        check("rst_rdy", 32'(u_if.cmd_rdy), 32'h0);
        check("rst_frm", 32'(u_if.frm_err), 32'h0);
        rst_n = 1'b1;
        repeat (2 * BAUD) @(negedge clk);

        // Basic pair A5,3C
        send_byte(8'hA5, 1'b1);
        check("hi_only_rdy", 32'(u_if.cmd_rdy), 32'h0);
        send_byte(8'h3C, 1'b1);
        check("a53c_cmd", 32'(u_if.cmd), 32'hA53C);
        check("a53c_rdy", 32'(u_if.cmd_rdy), 32'h1);
        check("a53c_frm", 32'(frm_cnt), 32'h0);
        lat = rise_cyc - t_start;
        check("a53c_latency_in_stop_bit", 32'(lat >= 9 * BAUD + 4 && lat <= 10 * BAUD), 32'h1);

        // Acknowledge
        pulse_clr();
        check("clr_rdy", 32'(u_if.cmd_rdy), 32'h0);
        check("clr_cmd_hold", 32'(u_if.cmd), 32'hA53C);

        // Framing error resynchronises pairing
        frm_base = frm_cnt;
        send_byte(8'h12, 1'b0);
        check("ferr_count", 32'(frm_cnt - frm_base), 32'h1);
        send_byte(8'h34, 1'b1);
        check("ferr_34_is_hi", 32'(u_if.cmd_rdy), 32'h0);
        send_byte(8'h56, 1'b1);
        check("ferr_cmd", 32'(u_if.cmd), 32'h3456);
        check("ferr_rdy", 32'(u_if.cmd_rdy), 32'h1);
        pulse_clr();

        // Short glitch while idle
        frm_base = frm_cnt;
        @(negedge clk);
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        repeat (3 * BAUD) @(negedge clk);
        check("glitch_frm", 32'(frm_cnt - frm_base), 32'h0);
        check("glitch_rdy", 32'(u_if.cmd_rdy), 32'h0);
        send_byte(8'hFF, 1'b1);
        send_byte(8'h00, 1'b1);
        check("glitch_cmd", 32'(u_if.cmd), 32'hFF00);
        check("glitch_rdy2", 32'(u_if.cmd_rdy), 32'h1);

        // Overwrite while cmd_rdy still set
        send_byte(8'h12, 1'b1);
        send_byte(8'h34, 1'b1);
        check("ovr_cmd", 32'(u_if.cmd), 32'h1234);
        check("ovr_rdy", 32'(u_if.cmd_rdy), 32'h1);

        // Reset in the middle of the low byte's data bits
        send_byte(8'h77, 1'b1);
        check("pre_rst_cmd", 32'(u_if.cmd), 32'h1234);
        @(negedge clk);
        rx = 1'b0;
        repeat (4 * BAUD) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_cmd", 32'(u_if.cmd), 32'h0000);
        check("midrst_rdy", 32'(u_if.cmd_rdy), 32'h0);
        check("midrst_frm", 32'(u_if.frm_err), 32'h0);
        rx = 1'b1;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (2 * BAUD) @(negedge clk);
        send_byte(8'hC3, 1'b1);
        send_byte(8'h0F, 1'b1);
        check("postrst_cmd", 32'(u_if.cmd), 32'hC30F);
        check("postrst_rdy", 32'(u_if.cmd_rdy), 32'h1);
        pulse_clr();

        // Long gap between high and low byte
        send_byte(8'h11, 1'b1);
        repeat (2500) @(negedge clk);
        send_byte(8'h22, 1'b1);
        send_byte(8'h33, 1'b1);
`ifdef CMD_BYTE_TIMEOUT_EN
        check("gap_cmd", 32'(u_if.cmd), 32'h2233);
`else
        check("gap_cmd", 32'(u_if.cmd), 32'h1122);
`endif
        check("gap_rdy", 32'(u_if.cmd_rdy), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
